// File: rtl/mul_bcd_seq_ctrl_if.sv
// Request/result bundle for the multiply-then-BCD controller.
// The master drives the operands and the result handshake; the slave returns status and result.
interface mul_bcd_seq_ctrl_if #(
  parameter int W = 4
);
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic [3:0]     bcd_hund;
  logic [3:0]     bcd_tens;
  logic [3:0]     bcd_units;

  modport master (
    output start, a, b, out_ready,
    input  busy, out_valid, product, bcd_hund, bcd_tens, bcd_units
  );

  modport slave (
    input  start, a, b, out_ready,
    output busy, out_valid, product, bcd_hund, bcd_tens, bcd_units
  );
endinterface

// File: rtl/mul_bcd_seq_ctrl.sv
// Multiplies by repeated addition, then converts to 3 BCD digits by double-dabble.
// Result valid b+2W edges after accept; held in DONE until out_ready, start ignored while busy.
module mul_bcd_seq_ctrl #(
  parameter int W = 4
) (
  input logic               clk,
  input logic               rst_n,
  mul_bcd_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL, CONV, DONE} state_t;

  localparam int          CW      = 12 + 2 * W;
  localparam logic [3:0]  LAST_IT = 4'(2 * W - 1);

  state_t         state;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   cnt;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  conv;
  logic [3:0]     it;
  logic [2*W-1:0] product_q;
  logic [3:0]     hund_q;
  logic [3:0]     tens_q;
  logic [3:0]     units_q;

  logic [CW-1:0]  conv_adj;
  logic [CW-1:0]  conv_next;
  logic [2*W-1:0] acc_sum;

  function automatic logic [3:0] dab(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    conv_adj              = conv;
    conv_adj[CW-1 -: 4]   = dab(conv[CW-1 -: 4]);
    conv_adj[CW-5 -: 4]   = dab(conv[CW-5 -: 4]);
    conv_adj[CW-9 -: 4]   = dab(conv[CW-9 -: 4]);
    conv_next             = conv_adj << 1;
    acc_sum               = acc + {{W{1'b0}}, a_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
      acc       <= '0;
      conv      <= '0;
      it        <= '0;
      product_q <= '0;
      hund_q    <= '0;
      tens_q    <= '0;
      units_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_q <= bus.a;
            b_q <= bus.b;
            acc <= '0;
            cnt <= '0;
            it  <= '0;
            if (bus.b != '0) begin
              state <= MUL;
            end else begin
              conv  <= '0;
              state <= CONV;
            end
          end
        end
        MUL: begin
          acc <= acc_sum;
          if (cnt == b_q - W'(1)) begin
            conv  <= {12'b0, acc_sum};
            it    <= '0;
            state <= CONV;
          end else begin
            cnt <= cnt + W'(1);
          end
        end
        CONV: begin
          conv <= conv_next;
          // acc still holds the binary product; the shifted field is consumed by the conversion
          if (it == LAST_IT) begin
            product_q <= acc;
            hund_q    <= conv_next[CW-1 -: 4];
            tens_q    <= conv_next[CW-5 -: 4];
            units_q   <= conv_next[CW-9 -: 4];
            state     <= DONE;
          end else begin
            it <= it + 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.product   = product_q;
  assign bus.bcd_hund  = hund_q;
  assign bus.bcd_tens  = tens_q;
  assign bus.bcd_units = units_q;

endmodule
